ltc2500_capture_ctrl: RTL
=========================

# ltc2500_capture_ctrl

Host-side controller for the 20-bit serial ADC (`adc_model` interface). On a start request it:
- pulses `convert`,
- waits for `busy` to rise and then fall,
- generates 20 `ser_clk` pulses, shifting `ser_data_out` MSB-first into a parallel word,
- presents the word with a one-cycle valid strobe.

It sits between the ADC pins and the sample-processing datapath, and replaces the hand-written stimulus used in bench-level ADC bring-up.

## Interface
Parameters:
- `DATA_W`, 20, conversion word width, equal to the number of `ser_clk` pulses.
- `CNV_HIGH_CYC`, 3, `convert` high time in `clk` cycles; ≥1.
- `SCK_HALF`, 4, `ser_clk` half-period in `clk` cycles; ≥3, so the synchronized data is settled.
- `TIMEOUT_CYC`, 1024, busy watchdog limit; used only with `LTC2500_CAPTURE_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock for the block; already decided.
- `rst` in 1: asynchronous, active-high reset; already decided.
- `start` in 1: conversion request; sampled only while `ready`=1.
- `ready` out 1: high in IDLE.
- `convert` out 1: to ADC, rising edge starts a conversion.
- `busy` in 1: from ADC, asynchronous.
- `ser_clk` out 1: to ADC, serial clock.
- `ser_data_out` in 1: from ADC, asynchronous serial data.
- `data` out DATA_W: last captured word; holds until the next capture.
- `data_valid` out 1: one-cycle strobe when `data` updates.
- `err` out 1: one-cycle strobe on busy timeout; tied 0 without the macro.

## Operation
- `busy` and `ser_data_out` each pass through a 2-flop synchronizer. All decisions use the synchronized versions, `busy_s` and `sdo_s`.
- ADC contract:
  - MSB is valid on `ser_data_out` once `busy` falls.
  - The next bit is driven after each `ser_clk` falling edge.
- FSM states and transitions:
  - IDLE: `ready`=1. On `start`=1, go to CNV.
  - CNV: `convert`=1 for exactly CNV_HIGH_CYC cycles, then WAIT_HI.
  - WAIT_HI: wait for `busy_s`=1, then WAIT_LO. If `busy_s` is already 1 on entry, go to WAIT_LO immediately.
  - WAIT_LO: wait for `busy_s`=0, then SHIFT.
  - SHIFT: emit DATA_W pulses. Each pulse is SCK_HALF cycles low, then SCK_HALF cycles high.
    - At the cycle `ser_clk` is driven high, shift `sdo_s` into the LSB of the shift register (`sr <= {sr[DATA_W-2:0], sdo_s}`).
    - The bit counter runs 0..DATA_W-1.
    - After the last high phase, go to DONE.
  - DONE: `ser_clk`=0, `data` <= `sr`, `data_valid`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored; there is no queuing.
- A `busy_s` glitch during SHIFT is ignored.
- `rst` asserted mid-operation: all state clears immediately and `convert` and `ser_clk` drop to 0 asynchronously. A partial word is never presented.

## Timing
- Reset values: `ready`=1, `convert`=0, `ser_clk`=0, `data`=0, `data_valid`=0, `err`=0. FSM=IDLE, counters=0.
- Outputs are registered. `ready` is decoded from the state register.
- Cycle timeline:
  - `start` high at edge N: `convert` rises at N+1 and falls at N+1+CNV_HIGH_CYC.
  - The synchronizers add 2 cycles of latency on `busy`.
  - The first `ser_clk` rise occurs SCK_HALF cycles after `busy_s` falls is seen.
- Shift duration is DATA_W·2·SCK_HALF cycles. `data_valid` follows the last `ser_clk` fall by 0 cycles, i.e. it is asserted in the same cycle.
- Minimum start-to-start period: CNV_HIGH_CYC + busy time + 2 + DATA_W·2·SCK_HALF + 2 cycles.

## Configuration
- `LTC2500_CAPTURE_TIMEOUT_EN` defined:
  - A counter runs in WAIT_HI and WAIT_LO and resets on each state entry.
  - Reaching TIMEOUT_CYC pulses `err` for one cycle and returns to IDLE.
  - `data` and `data_valid` are untouched.
- Not defined: the watchdog is absent, the FSM waits indefinitely, and `err` is constant 0.

## Structure
- Package `ltc2500_pkg` holds:
  - the FSM state enum (IDLE, CNV, WAIT_HI, WAIT_LO, SHIFT, DONE);
  - default constants `LTC2500_DATA_W`=20, `LTC2500_SCK_HALF`=4.
- Sub-module `sync2`: generic 2-flop synchronizer with async active-high reset to 0. It is instantiated twice.
- The rest of the logic (FSM, half-period counter, bit counter, shift register) lives in one module.

## Test plan
- Reset then single `start` with `adc_model` input 0xA5A5A -> one `convert` pulse 3 cycles wide; exactly 20 `ser_clk` pulses of 8 cycles each; `data`=0xA5A5A with one `data_valid` pulse; `ready` back to 1.
- Repeated `start` held high for 5 back-to-back captures, model data incrementing -> each `data` = previous + captured delta; no extra `convert` pulses while not `ready`.
- Data patterns 0x00000, 0xFFFFF, 0x80000 and 0x00001 -> captured exactly; MSB/LSB ordering verified.
- `rst` pulsed in the middle of SHIFT (bit 10) -> `ser_clk`=0 and `convert`=0 immediately; no `data_valid`; `data` keeps its prior value; the next capture is correct.
- With `LTC2500_CAPTURE_TIMEOUT_EN` and `busy` stuck low -> `err` pulses once, TIMEOUT_CYC cycles after entering WAIT_HI; `ready`=1 the next cycle. Without the macro -> FSM stays in WAIT_HI and `err` stays 0.

Source files
------------

// File: rtl/ltc2500_pkg.sv
// Shared types and defaults for the LTC2500 capture controller.
package ltc2500_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNV,
    WAIT_HI,
    WAIT_LO,
    SHIFT,
    DONE
  } state_t;

  localparam int LTC2500_DATA_W   = 20;
  localparam int LTC2500_SCK_HALF = 4;

  // Bits needed to count 0..n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ltc2500_capture_ctrl_if.sv
// ADC pin and sample-bus bundle between the capture controller and its surroundings.
interface ltc2500_capture_ctrl_if import ltc2500_pkg::*; #(
  parameter int DATA_W = LTC2500_DATA_W
);
  logic              start;
  logic              ready;
  logic              convert;
  logic              busy;
  logic              ser_clk;
  logic              ser_data_out;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              err;

  modport master (
    input  start, busy, ser_data_out,
    output ready, convert, ser_clk, data, data_valid, err
  );

  modport slave (
    output start, busy, ser_data_out,
    input  ready, convert, ser_clk, data, data_valid, err
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[0], i_d};
  end

  assign o_q = r_sync[1];
endmodule

// File: rtl/ltc2500_capture_ctrl.sv
// Host-side conversion/readout controller for the 20-bit serial ADC.
// Optional busy watchdog enabled by defining LTC2500_CAPTURE_TIMEOUT_EN.
module ltc2500_capture_ctrl import ltc2500_pkg::*; #(
  parameter int DATA_W       = LTC2500_DATA_W,
  parameter int CNV_HIGH_CYC = 3,
  parameter int SCK_HALF     = LTC2500_SCK_HALF
`ifdef LTC2500_CAPTURE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC  = 1024
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  ltc2500_capture_ctrl_if.master  bus
);
  localparam int CNT_W = cnt_w((CNV_HIGH_CYC > SCK_HALF) ? CNV_HIGH_CYC : SCK_HALF);
  localparam int BIT_W = cnt_w(DATA_W);

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [BIT_W-1:0]  r_bit, w_bit_next;
  logic              r_phase, w_phase_next;
  logic [DATA_W-1:0] r_sr, w_sr_next;
  logic [DATA_W-1:0] r_data, w_data_next;
  logic              r_convert, w_convert_next;
  logic              r_ser_clk, w_ser_clk_next;
  logic              r_data_valid, w_data_valid_next;
  logic [1:0]        w_async, w_synced;
  logic              w_busy_s, w_sdo_s;

  assign w_async = {bus.ser_data_out, bus.busy};

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_sync
    sync2 u_sync2 (.clk(clk), .rst(rst), .i_d(w_async[gi]), .o_q(w_synced[gi]));
  end

  assign w_busy_s = w_synced[0];
  assign w_sdo_s  = w_synced[1];

`ifdef LTC2500_CAPTURE_TIMEOUT_EN
  localparam int WD_W = cnt_w(TIMEOUT_CYC);
  logic [WD_W-1:0] r_wd, w_wd_next;
  logic            r_err, w_err_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      r_wd  <= w_wd_next;
      r_err <= w_err_next;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_bit_next        = r_bit;
    w_phase_next      = r_phase;
    w_sr_next         = r_sr;
    w_data_next       = r_data;
    w_convert_next    = 1'b0;
    w_ser_clk_next    = r_ser_clk;
    w_data_valid_next = 1'b0;
`ifdef LTC2500_CAPTURE_TIMEOUT_EN
    // Watchdog clears every cycle it is not explicitly advanced, so each wait state starts at 0.
    w_wd_next  = '0;
    w_err_next = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = CNV;
          w_cnt_next   = '0;
        end
      end
      CNV: begin
        w_convert_next = 1'b1;
        if (r_cnt == CNT_W'(CNV_HIGH_CYC - 1)) w_state_next = WAIT_HI;
        else                                   w_cnt_next   = r_cnt + 1'b1;
      end
      WAIT_HI: begin
        if (w_busy_s) w_state_next = WAIT_LO;
`ifdef LTC2500_CAPTURE_TIMEOUT_EN
        else if (r_wd == WD_W'(TIMEOUT_CYC - 1)) begin
          w_state_next = IDLE;
          w_err_next   = 1'b1;
        end else w_wd_next = r_wd + 1'b1;
`endif
      end
      WAIT_LO: begin
        if (!w_busy_s) begin
          w_state_next = SHIFT;
          w_cnt_next   = '0;
          w_bit_next   = '0;
          w_phase_next = 1'b0;
        end
`ifdef LTC2500_CAPTURE_TIMEOUT_EN
        else if (r_wd == WD_W'(TIMEOUT_CYC - 1)) begin
          w_state_next = IDLE;
          w_err_next   = 1'b1;
        end else w_wd_next = r_wd + 1'b1;
`endif
      end
      SHIFT: begin
        if (r_cnt == CNT_W'(SCK_HALF - 1)) begin
          w_cnt_next   = '0;
          w_phase_next = ~r_phase;
          if (!r_phase) begin
            // Rising edge: sdo_s has had a full low phase to settle after the previous fall.
            w_ser_clk_next = 1'b1;
            w_sr_next      = {r_sr[DATA_W-2:0], w_sdo_s};
          end else begin
            w_ser_clk_next = 1'b0;
            if (r_bit == BIT_W'(DATA_W - 1)) begin
              w_state_next      = DONE;
              w_data_next       = r_sr;
              w_data_valid_next = 1'b1;
            end else w_bit_next = r_bit + 1'b1;
          end
        end else w_cnt_next = r_cnt + 1'b1;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_bit        <= '0;
      r_phase      <= 1'b0;
      r_sr         <= '0;
      r_data       <= '0;
      r_convert    <= 1'b0;
      r_ser_clk    <= 1'b0;
      r_data_valid <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_next;
      r_bit        <= w_bit_next;
      r_phase      <= w_phase_next;
      r_sr         <= w_sr_next;
      r_data       <= w_data_next;
      r_convert    <= w_convert_next;
      r_ser_clk    <= w_ser_clk_next;
      r_data_valid <= w_data_valid_next;
    end
  end

  assign bus.ready      = (r_state == IDLE);
  assign bus.convert    = r_convert;
  assign bus.ser_clk    = r_ser_clk;
  assign bus.data       = r_data;
  assign bus.data_valid = r_data_valid;
endmodule
